// File: rtl/clint_timer_pkg.sv
// Shared register map, CTRL bit positions and byte-lane helper for the CLINT timer.
package clint_timer_pkg;

  typedef enum logic [2:0] {
    OfsMtimeLo = 3'd0,
    OfsMtimeHi = 3'd1,
    OfsCmpLo   = 3'd2,
    OfsCmpHi   = 3'd3,
    OfsCtrl    = 3'd4,
    OfsStatus  = 3'd5
  } reg_ofs_e;

  localparam int unsigned CNT_EN_BIT = 0;
  localparam int unsigned IRQ_EN_BIT = 1;

  localparam logic [63:0] MTIME_RESET = 64'h0;
  localparam logic [63:0] CMP_RESET   = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace only the byte lanes whose mask bit is set.
  function automatic logic [31:0] merge_lanes(input logic [31:0] cur, input logic [31:0] wdata,
                                              input logic [3:0] mask);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Tick generator: one tick every PRESCALE enabled cycles; holds its count while disabled.
module clint_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clint_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, LO-read HI snapshot, level interrupt.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_data,
  input  logic [3:0]  I_mask,
  output logic [31:0] O_data,
  output logic        O_ready,
  output logic        O_timer_int
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic [31:0] snap_hi_q, snap_hi_d;
  logic        cnt_en_q, cnt_en_d;
  logic        irq_en_q, irq_en_d;
  logic        timer_int_q;
  logic        hit, rd, wr, tick, expired;
  reg_ofs_e    ofs;

  assign hit     = I_req && ((I_addr & ~32'h1F) == BASE_ADDR);
  assign rd      = hit && !I_we;
  assign wr      = hit && I_we;
  assign ofs     = reg_ofs_e'(I_addr[4:2]);
  assign expired = (mtime_q >= cmp_q);

  clint_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en_q),
    .tick(tick)
  );

  always_comb begin
    O_data = 32'h0;
    if (rd) begin
      case (ofs)
        OfsMtimeLo: O_data = mtime_q[31:0];
        OfsMtimeHi: O_data = snap_hi_q;
        OfsCmpLo:   O_data = cmp_q[31:0];
        OfsCmpHi:   O_data = cmp_q[63:32];
        OfsCtrl:    O_data = {30'h0, irq_en_q, cnt_en_q};
        OfsStatus:  O_data = {31'h0, expired};
        default:    O_data = 32'h0;
      endcase
    end
  end

  assign O_ready     = hit;
  assign O_timer_int = timer_int_q;

  // A software write to either mtime half replaces the increment for that cycle.
  always_comb begin
    mtime_d   = tick ? (mtime_q + 64'd1) : mtime_q;
    cmp_d     = cmp_q;
    snap_hi_d = snap_hi_q;
    cnt_en_d  = cnt_en_q;
    irq_en_d  = irq_en_q;
    if (rd && (ofs == OfsMtimeLo)) begin
      snap_hi_d = mtime_q[63:32];
    end
    if (wr) begin
      case (ofs)
        OfsMtimeLo: mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], I_data, I_mask)};
        OfsMtimeHi: mtime_d = {merge_lanes(mtime_q[63:32], I_data, I_mask), mtime_q[31:0]};
        OfsCmpLo:   cmp_d   = {cmp_q[63:32], merge_lanes(cmp_q[31:0], I_data, I_mask)};
        OfsCmpHi:   cmp_d   = {merge_lanes(cmp_q[63:32], I_data, I_mask), cmp_q[31:0]};
        OfsCtrl: begin
          if (I_mask[0]) begin
            cnt_en_d = I_data[CNT_EN_BIT];
            irq_en_d = I_data[IRQ_EN_BIT];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q     <= MTIME_RESET;
      cmp_q       <= CMP_RESET;
      snap_hi_q   <= 32'h0;
      cnt_en_q    <= 1'b1;
      irq_en_q    <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      cmp_q       <= cmp_d;
      snap_hi_q   <= snap_hi_d;
      cnt_en_q    <= cnt_en_d;
      irq_en_q    <= irq_en_d;
      timer_int_q <= irq_en_q && expired;
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: directed bus accesses with hand-computed expectations.
module tb_clint_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  mask = 4'h0;
  int          sel_r = 0;
  logic        probe = 1'b0;

  logic        req1, req4;
  logic [31:0] d1_data, d4_data;
  logic        d1_ready, d4_ready, d1_int, d4_int;

  assign req1 = req && (sel_r == 0);
  assign req4 = req && (sel_r == 1);

  always #5 clk = ~clk;

  clint_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .I_req(req1), .I_we(we), .I_addr(addr), .I_data(wdata),
    .I_mask(mask), .O_data(d1_data), .O_ready(d1_ready), .O_timer_int(d1_int)
  );

  clint_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .I_req(req4), .I_we(we), .I_addr(addr), .I_data(wdata),
    .I_mask(mask), .O_data(d4_data), .O_ready(d4_ready), .O_timer_int(d4_int)
  );

  typedef struct {
    int          sel;
    string       name;
    logic [31:0] data;
    logic        ready;
    bit          chk_int;
    logic        intr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: pops one expectation per probed cycle and compares the DUT outputs.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a_data;
    logic        a_ready, a_int;
    if (probe) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: probe with no expectation at %0t", $time);
      end else begin
        e       = sb.pop_front();
        a_data  = (e.sel == 1) ? d4_data : d1_data;
        a_ready = (e.sel == 1) ? d4_ready : d1_ready;
        a_int   = (e.sel == 1) ? d4_int : d1_int;
        n_cmp++;
        if (a_ready !== e.ready) begin
          n_bad++;
          $display("FAIL %s.ready: got %b expected %b", e.name, a_ready, e.ready);
        end
        n_cmp++;
        if (a_data !== e.data) begin
          n_bad++;
          $display("FAIL %s.data: got %h expected %h", e.name, a_data, e.data);
        end
        if (e.chk_int) begin
          n_cmp++;
          if (a_int !== e.intr) begin
            n_bad++;
            $display("FAIL %s.int: got %b expected %b", e.name, a_int, e.intr);
          end
        end
      end
    end
  end

  task automatic bus(input int sel, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m, input bit chk, input string name,
                     input logic [31:0] exp_data, input logic exp_ready, input bit chk_int,
                     input logic exp_int);
    exp_t e;
    sel_r = sel;
    req   = r;
    we    = w;
    addr  = a;
    wdata = d;
    mask  = m;
    if (chk) begin
      e.sel = sel; e.name = name; e.data = exp_data; e.ready = exp_ready;
      e.chk_int = chk_int; e.intr = exp_int;
      sb.push_back(e);
      probe = 1'b1;
    end
    @(posedge clk);
    #1;
    probe = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
  endtask

  task automatic rd(input int sel, input logic [2:0] ofs, input string name,
                    input logic [31:0] exp_data, input bit chk_int, input logic exp_int);
    bus(sel, 1'b1, 1'b0, BASE + {27'h0, ofs, 2'b00}, 32'h0, 4'h0, 1'b1, name, exp_data, 1'b1,
        chk_int, exp_int);
  endtask

  task automatic wr(input int sel, input logic [2:0] ofs, input logic [31:0] d,
                    input logic [3:0] m);
    bus(sel, 1'b1, 1'b1, BASE + {27'h0, ofs, 2'b00}, d, m, 1'b1, "write", 32'h0, 1'b1,
        1'b0, 1'b0);
  endtask

  task automatic idle_int(input string name, input logic exp_int);
    bus(0, 1'b0, 1'b0, BASE, 32'h0, 4'h0, 1'b1, name, 32'h0, 1'b0, 1'b1, exp_int);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [31:0] EXP_T5 [8] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;

    // 1: reset state and free-running count with PRESCALE=1
    do_reset();
    rd(0, 3'd0, "t1_lo0", 32'd0, 1'b1, 1'b0);
    rd(0, 3'd0, "t1_lo1", 32'd1, 1'b1, 1'b0);
    rd(0, 3'd0, "t1_lo2", 32'd2, 1'b1, 1'b0);
    rd(0, 3'd4, "t1_ctrl", 32'h1, 1'b1, 1'b0);
    rd(0, 3'd1, "t1_snap", 32'h0, 1'b1, 1'b0);
    rd(0, 3'd5, "t1_status", 32'h0, 1'b1, 1'b0);
    rd(0, 3'd2, "t1_cmplo", 32'hFFFF_FFFF, 1'b0, 1'b0);
    rd(0, 3'd6, "t1_ofs18", 32'h0, 1'b0, 1'b0);

    // 2: carry into HI and tear-free snapshot
    do_reset();
    wr(0, 3'd4, 32'h0, 4'hF);
    wr(0, 3'd0, 32'hFFFF_FFFF, 4'hF);
    wr(0, 3'd4, 32'h1, 4'hF);
    rd(0, 3'd0, "t2_lo_max", 32'hFFFF_FFFF, 1'b0, 1'b0);
    rd(0, 3'd0, "t2_lo_wrap", 32'h0, 1'b0, 1'b0);
    wr(0, 3'd1, 32'h5, 4'hF);
    rd(0, 3'd1, "t2_hi_snap", 32'h1, 1'b0, 1'b0);
    rd(0, 3'd0, "t2_lo_after", 32'h2, 1'b0, 1'b0);
    rd(0, 3'd1, "t2_hi_new", 32'h5, 1'b0, 1'b0);

    // 3: interrupt lags mtime reaching cmp by one cycle; raising cmp clears it
    do_reset();
    wr(0, 3'd4, 32'h0, 4'hF);
    wr(0, 3'd3, 32'h0, 4'hF);
    wr(0, 3'd2, 32'd10, 4'hF);
    wr(0, 3'd0, 32'h0, 4'hF);
    wr(0, 3'd4, 32'h3, 4'hF);
    for (int i = 0; i < 10; i++) idle_int("t3_idle", 1'b0);
    rd(0, 3'd0, "t3_lo10", 32'd10, 1'b1, 1'b0);
    rd(0, 3'd5, "t3_status", 32'h1, 1'b1, 1'b1);
    wr(0, 3'd3, 32'h1, 4'hF);
    rd(0, 3'd5, "t3_lag", 32'h0, 1'b1, 1'b1);
    rd(0, 3'd5, "t3_clear", 32'h0, 1'b1, 1'b0);

    // 4: byte-lane write, colliding tick dropped
    do_reset();
    wr(0, 3'd0, 32'h1234_0000, 4'hF);
    wr(0, 3'd0, 32'hFFFF_0100, 4'b0011);
    rd(0, 3'd0, "t4_lanes", 32'h1234_0100, 1'b0, 1'b0);
    rd(0, 3'd0, "t4_next", 32'h1234_0101, 1'b0, 1'b0);
    rd(0, 3'd1, "t4_hi", 32'h0, 1'b0, 1'b0);

    // 5: PRESCALE=4 freeze and resume
    do_reset();
    wr(1, 3'd4, 32'h0, 4'hF);
    for (int i = 0; i < 10; i++) rd(1, 3'd0, "t5_frozen", 32'h0, 1'b0, 1'b0);
    wr(1, 3'd4, 32'h1, 4'hF);
    for (int i = 0; i < 8; i++) rd(1, 3'd0, "t5_run", EXP_T5[i], 1'b0, 1'b0);

    // 6: misses, idle requests, and reset in the middle of counting
    do_reset();
    wr(0, 3'd4, 32'h0, 4'hF);
    bus(0, 1'b1, 1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b1, "t6_miss_wr", 32'h0, 1'b0,
        1'b0, 1'b0);
    bus(0, 1'b1, 1'b0, BASE + 32'h40, 32'h0, 4'h0, 1'b1, "t6_miss_rd", 32'h0, 1'b0, 1'b0, 1'b0);
    bus(0, 1'b0, 1'b0, BASE, 32'h0, 4'h0, 1'b1, "t6_noreq_rd", 32'h0, 1'b0, 1'b0, 1'b0);
    bus(0, 1'b0, 1'b1, BASE, 32'h55, 4'hF, 1'b1, "t6_noreq_wr", 32'h0, 1'b0, 1'b0, 1'b0);
    rd(0, 3'd0, "t6_unchanged", 32'h1, 1'b0, 1'b0);
    wr(0, 3'd4, 32'h3, 4'hF);
    wr(0, 3'd3, 32'h0, 4'hF);
    wr(0, 3'd2, 32'h0, 4'hF);
    idle_int("t6_int_lag", 1'b0);
    idle_int("t6_int_set", 1'b1);
    rst = 1'b1;
    bus(0, 1'b1, 1'b1, BASE, 32'hDEAD, 4'hF, 1'b0, "", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    rd(0, 3'd0, "t6_rst_lo", 32'h0, 1'b1, 1'b0);
    rd(0, 3'd0, "t6_rst_cnt", 32'h1, 1'b1, 1'b0);
    rd(0, 3'd4, "t6_rst_ctrl", 32'h1, 1'b0, 1'b0);
    rd(0, 3'd2, "t6_rst_cmplo", 32'hFFFF_FFFF, 1'b0, 1'b0);
    rd(0, 3'd3, "t6_rst_cmphi", 32'hFFFF_FFFF, 1'b0, 1'b0);
    rd(0, 3'd1, "t6_rst_snap", 32'h0, 1'b0, 1'b0);

    // 7: full 64-bit wrap and unsigned equality compare
    do_reset();
    wr(0, 3'd4, 32'h0, 4'hF);
    wr(0, 3'd0, 32'hFFFF_FFFF, 4'hF);
    wr(0, 3'd1, 32'hFFFF_FFFF, 4'hF);
    wr(0, 3'd4, 32'h1, 4'hF);
    rd(0, 3'd5, "t7_status_max", 32'h1, 1'b0, 1'b0);
    rd(0, 3'd0, "t7_wrap_lo", 32'h0, 1'b0, 1'b0);
    rd(0, 3'd1, "t7_wrap_hi", 32'h0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
